// File: rtl/dual_stepper_driver.sv
// Two-axis step/dir pulse generator: a relative move command steps both joints
// together at a fixed pulse rate while tracking each joint's signed position.
module dual_stepper_driver #(
  parameter int STEP_HIGH_CYCLES = 50,
  parameter int STEP_LOW_CYCLES  = 50,
  parameter int DIR_SETUP_CYCLES = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [8:0]        th1_steps,
  input  logic [8:0]        th2_steps,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              abort,
  output logic              step1,
  output logic              step2,
  output logic              dir1,
  output logic              dir2,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [15:0]       th1_pos,
  output logic [15:0]       th2_pos
);
  localparam int MAXC = (STEP_HIGH_CYCLES > STEP_LOW_CYCLES) ?
                        ((STEP_HIGH_CYCLES > DIR_SETUP_CYCLES) ? STEP_HIGH_CYCLES : DIR_SETUP_CYCLES) :
                        ((STEP_LOW_CYCLES  > DIR_SETUP_CYCLES) ? STEP_LOW_CYCLES  : DIR_SETUP_CYCLES);
  localparam int CW = (MAXC < 2) ? 1 : $clog2(MAXC);

  typedef enum logic [2:0] {IDLE, SETUP, PULSE_HI, PULSE_LO, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [8:0]    rem1_q, rem1_d, rem2_q, rem2_d;
  logic          dir1_q, dir1_d, dir2_q, dir2_d;
  logic [15:0]   pos1_q, pos1_d, pos2_q, pos2_d;
  logic          step1_q, step1_d, step2_q, step2_d;
  logic          abt_q, abt_d;
  logic          init_q;
  logic          go_hi, go_abort;
  logic [8:0]    abs1, abs2;

  // Magnitude of a 9-bit two's complement value; -256 maps to 9'h100 = 256.
  assign abs1 = th1_steps[8] ? 9'(-th1_steps) : th1_steps;
  assign abs2 = th2_steps[8] ? 9'(-th2_steps) : th2_steps;

  assign cmd_ready = (state_q == IDLE) && init_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign aborted   = abt_q;
  assign step1     = step1_q;
  assign step2     = step2_q;
  assign dir1      = dir1_q;
  assign dir2      = dir2_q;
  assign th1_pos   = pos1_q;
  assign th2_pos   = pos2_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem1_d   = rem1_q;
    rem2_d   = rem2_q;
    dir1_d   = dir1_q;
    dir2_d   = dir2_q;
    pos1_d   = pos1_q;
    pos2_d   = pos2_q;
    step1_d  = step1_q;
    step2_d  = step2_q;
    abt_d    = 1'b0;
    go_hi    = 1'b0;
    go_abort = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          rem1_d = abs1;
          rem2_d = abs2;
          if (abs1 == 9'd0 && abs2 == 9'd0) begin
            state_d = DONE;
          end else begin
            state_d = SETUP;
            dir1_d  = ~th1_steps[8];
            dir2_d  = ~th2_steps[8];
            cnt_d   = CW'(DIR_SETUP_CYCLES - 1);
          end
        end
      end
      SETUP: begin
        if (abort)                go_abort = 1'b1;
        else if (cnt_q == '0)     go_hi    = 1'b1;
        else                      cnt_d    = cnt_q - 1'b1;
      end
      PULSE_HI: begin
        if (abort) go_abort = 1'b1;
        else if (cnt_q == '0) begin
          state_d = PULSE_LO;
          cnt_d   = CW'(STEP_LOW_CYCLES - 1);
          step1_d = 1'b0;
          step2_d = 1'b0;
        end else cnt_d = cnt_q - 1'b1;
      end
      PULSE_LO: begin
        if (abort) go_abort = 1'b1;
        else if (cnt_q == '0) begin
          if (rem1_q != 9'd0 || rem2_q != 9'd0) go_hi   = 1'b1;
          else                                  state_d = DONE;
        end else cnt_d = cnt_q - 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Position is committed at pulse start, so a pulse cut short still counts.
    if (go_hi) begin
      state_d = PULSE_HI;
      cnt_d   = CW'(STEP_HIGH_CYCLES - 1);
      step1_d = (rem1_q != 9'd0);
      step2_d = (rem2_q != 9'd0);
      if (rem1_q != 9'd0) begin
        rem1_d = rem1_q - 9'd1;
        pos1_d = dir1_q ? pos1_q + 16'd1 : pos1_q - 16'd1;
      end
      if (rem2_q != 9'd0) begin
        rem2_d = rem2_q - 9'd1;
        pos2_d = dir2_q ? pos2_q + 16'd1 : pos2_q - 16'd1;
      end
    end
    if (go_abort) begin
      state_d = DONE;
      step1_d = 1'b0;
      step2_d = 1'b0;
      rem1_d  = 9'd0;
      rem2_d  = 9'd0;
      abt_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem1_q  <= 9'd0;
      rem2_q  <= 9'd0;
      dir1_q  <= 1'b1;
      dir2_q  <= 1'b1;
      pos1_q  <= 16'd0;
      pos2_q  <= 16'd0;
      step1_q <= 1'b0;
      step2_q <= 1'b0;
      abt_q   <= 1'b0;
      init_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem1_q  <= rem1_d;
      rem2_q  <= rem2_d;
      dir1_q  <= dir1_d;
      dir2_q  <= dir2_d;
      pos1_q  <= pos1_d;
      pos2_q  <= pos2_d;
      step1_q <= step1_d;
      step2_q <= step2_d;
      abt_q   <= abt_d;
      init_q  <= 1'b1;
    end
  end
endmodule

// File: tb/tb_dual_stepper_driver.sv
// Directed bench for dual_stepper_driver with 2/2/1 cycle timing; cycle k is
// sampled at the falling edge after the k-th rising edge following acceptance.
module tb_dual_stepper_driver;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [8:0]  th1_steps = '0, th2_steps = '0;
  logic        cmd_valid = 1'b0, abort = 1'b0;
  logic        cmd_ready, step1, step2, dir1, dir2, busy, done, aborted;
  logic [15:0] th1_pos, th2_pos;

  int errors = 0;
  int checks = 0;

  logic s1 [0:1100];
  logic s2 [0:1100];
  logic dn [0:1100];
  logic ab [0:1100];
  logic d1 [0:1100];
  logic d2 [0:1100];
  logic bs [0:1100];
  logic rd [0:1100];
  logic rdy0;

  dual_stepper_driver #(
    .STEP_HIGH_CYCLES(2), .STEP_LOW_CYCLES(2), .DIR_SETUP_CYCLES(1)
  ) dut (
    .clk(clk), .reset(reset), .th1_steps(th1_steps), .th2_steps(th2_steps),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .abort(abort),
    .step1(step1), .step2(step2), .dir1(dir1), .dir2(dir2), .busy(busy),
    .done(done), .aborted(aborted), .th1_pos(th1_pos), .th2_pos(th2_pos)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  // Issues one command, then records outputs for cycles 1..n; abort is raised
  // during cycle abort_at. Command inputs are scrambled after acceptance.
  task automatic run_move(input logic [8:0] a, input logic [8:0] b, input int n, input int abort_at);
    th1_steps = a;
    th2_steps = b;
    cmd_valid = 1'b1;
    rdy0 = cmd_ready;
    @(negedge clk);
    cmd_valid = 1'b0;
    th1_steps = 9'h0AA;
    th2_steps = 9'h155;
    for (int k = 1; k <= n; k++) begin
      s1[k] = step1; s2[k] = step2; dn[k] = done; ab[k] = aborted;
      d1[k] = dir1;  d2[k] = dir2;  bs[k] = busy; rd[k] = cmd_ready;
      abort = (k == abort_at);
      @(negedge clk);
    end
    abort = 1'b0;
  endtask

  function automatic int pulses(input int which, input int n);
    int c = 0;
    logic prev = 1'b0;
    for (int k = 1; k <= n; k++) begin
      logic cur;
      cur = (which == 1) ? s1[k] : s2[k];
      if (cur && !prev) c++;
      prev = cur;
    end
    return c;
  endfunction

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({step1, step2, dir1, dir2, busy, done, aborted, cmd_ready} !== 8'b0011_0000) begin
      errors++; $display("FAIL reset_outputs got=%b want=00110000", {step1, step2, dir1, dir2, busy, done, aborted, cmd_ready});
    end
    checks++;
    if (th1_pos !== 16'd0 || th2_pos !== 16'd0) begin
      errors++; $display("FAIL reset_pos got=%h/%h want=0000/0000", th1_pos, th2_pos);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready got=%b want=1", cmd_ready);
    end
  endtask

  task automatic test_single();
    run_move(9'd3, 9'd0, 16, 0);
    checks++;
    if (rdy0 !== 1'b1) begin errors++; $display("FAIL single_accept_ready got=%b want=1", rdy0); end
    checks++;
    if (d1[1] !== 1'b1 || bs[1] !== 1'b1) begin errors++; $display("FAIL single_dir_busy got=%b%b want=11", d1[1], bs[1]); end
    for (int k = 1; k <= 16; k++) begin
      logic e1;
      e1 = (k == 2 || k == 3 || k == 6 || k == 7 || k == 10 || k == 11);
      checks++;
      if (s1[k] !== e1 || s2[k] !== 1'b0 || dn[k] !== (k == 14)) begin
        errors++; $display("FAIL single_c%0d step1/step2/done got=%b%b%b want=%b0%b", k, s1[k], s2[k], dn[k], e1, (k == 14));
      end
    end
    checks++;
    if (ab[14] !== 1'b0 || rd[15] !== 1'b1 || bs[15] !== 1'b0) begin
      errors++; $display("FAIL single_end aborted/ready/busy got=%b%b%b want=010", ab[14], rd[15], bs[15]);
    end
    checks++;
    if (th1_pos !== 16'd3 || th2_pos !== 16'd0) begin errors++; $display("FAIL single_pos got=%h/%h want=0003/0000", th1_pos, th2_pos); end
  endtask

  task automatic test_dual();
    do_reset();
    run_move(9'h1FE, 9'd5, 24, 0);
    checks++;
    if (d1[1] !== 1'b0 || d2[1] !== 1'b1) begin errors++; $display("FAIL dual_dir got=%b%b want=01", d1[1], d2[1]); end
    for (int k = 1; k <= 24; k++) begin
      logic e1;
      e1 = (k == 2 || k == 3 || k == 6 || k == 7);
      checks++;
      if (s1[k] !== e1 || dn[k] !== (k == 22)) begin
        errors++; $display("FAIL dual_c%0d step1/done got=%b%b want=%b%b", k, s1[k], dn[k], e1, (k == 22));
      end
    end
    checks++;
    if (pulses(2, 24) !== 5) begin errors++; $display("FAIL dual_step2_pulses got=%0d want=5", pulses(2, 24)); end
    checks++;
    if (th1_pos !== 16'hFFFE || th2_pos !== 16'd5) begin errors++; $display("FAIL dual_pos got=%h/%h want=fffe/0005", th1_pos, th2_pos); end
  endtask

  // Runs after test_dual: dir1 is 0 and must not change on a null move.
  task automatic test_zero();
    run_move(9'd0, 9'd0, 4, 0);
    checks++;
    if (dn[1] !== 1'b1 || rd[2] !== 1'b1 || dn[2] !== 1'b0) begin
      errors++; $display("FAIL zero_done_ready got=%b%b%b want=110", dn[1], rd[2], dn[2]);
    end
    checks++;
    if (pulses(1, 4) != 0 || pulses(2, 4) != 0 || d1[1] !== 1'b0 || d2[1] !== 1'b1) begin
      errors++; $display("FAIL zero_nostep_dir got=%0d/%0d dir=%b%b want=0/0 dir=01", pulses(1, 4), pulses(2, 4), d1[1], d2[1]);
    end
    checks++;
    if (th1_pos !== 16'hFFFE || th2_pos !== 16'd5) begin errors++; $display("FAIL zero_pos got=%h/%h want=fffe/0005", th1_pos, th2_pos); end
  endtask

  task automatic test_full_neg();
    do_reset();
    run_move(9'h100, 9'd0, 1030, 0);
    checks++;
    if (pulses(1, 1030) != 256) begin errors++; $display("FAIL neg256_pulses got=%0d want=256", pulses(1, 1030)); end
    checks++;
    if (dn[1026] !== 1'b1 || dn[1025] !== 1'b0 || d1[1] !== 1'b0) begin
      errors++; $display("FAIL neg256_done got=%b%b dir=%b want=01 dir=0", dn[1025], dn[1026], d1[1]);
    end
    checks++;
    if (th1_pos !== 16'hFF00) begin errors++; $display("FAIL neg256_pos got=%h want=ff00", th1_pos); end
  endtask

  task automatic test_abort();
    do_reset();
    run_move(9'd4, 9'd0, 12, 7);
    checks++;
    if (s1[7] !== 1'b1 || s1[8] !== 1'b0) begin errors++; $display("FAIL abort_step got=%b%b want=10", s1[7], s1[8]); end
    checks++;
    if (dn[8] !== 1'b1 || ab[8] !== 1'b1 || dn[7] !== 1'b0) begin
      errors++; $display("FAIL abort_done got=%b%b prev=%b want=11 prev=0", dn[8], ab[8], dn[7]);
    end
    checks++;
    if (pulses(1, 12) != 2 || ab[9] !== 1'b0 || rd[9] !== 1'b1) begin
      errors++; $display("FAIL abort_after pulses=%0d ab=%b rdy=%b want=2 0 1", pulses(1, 12), ab[9], rd[9]);
    end
    checks++;
    if (th1_pos !== 16'd2) begin errors++; $display("FAIL abort_pos got=%h want=0002", th1_pos); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    th1_steps = 9'd3; th2_steps = 9'd0; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      if (k == 2) begin
        checks++;
        if (step1 !== 1'b1 || th1_pos !== 16'd1) begin errors++; $display("FAIL rstmid_pre got=%b/%h want=1/0001", step1, th1_pos); end
      end
      if (k == 5) reset = 1'b0;
      @(negedge clk);
    end
    checks++;
    if ({step1, step2, dir1, dir2, busy, done, aborted, cmd_ready} !== 8'b0011_0000 || th1_pos !== 16'd0) begin
      errors++; $display("FAIL rstmid_outputs got=%b pos=%h want=00110000 pos=0000", {step1, step2, dir1, dir2, busy, done, aborted, cmd_ready}, th1_pos);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || step1 !== 1'b0 || th1_pos !== 16'd0) begin
      errors++; $display("FAIL rstmid_release rdy=%b step=%b pos=%h want=1 0 0000", cmd_ready, step1, th1_pos);
    end
  endtask

  // cmd_valid held: +1 moves back to back, with garbage on th1 mid-move.
  task automatic test_back_to_back();
    do_reset();
    th1_steps = 9'd1; th2_steps = 9'd0; cmd_valid = 1'b1;
    @(negedge clk);
    for (int k = 1; k <= 14; k++) begin
      s1[k] = step1; dn[k] = done; rd[k] = cmd_ready;
      th1_steps = (k >= 1 && k <= 5) ? 9'h1F9 : 9'd1;
      if (k == 13) cmd_valid = 1'b0;
      @(negedge clk);
    end
    for (int k = 1; k <= 14; k++) begin
      logic es, ed;
      es = (k == 2 || k == 3 || k == 9 || k == 10);
      ed = (k == 6 || k == 13);
      checks++;
      if (s1[k] !== es || dn[k] !== ed) begin
        errors++; $display("FAIL b2b_c%0d step1/done got=%b%b want=%b%b", k, s1[k], dn[k], es, ed);
      end
    end
    checks++;
    if (rd[7] !== 1'b1 || rd[8] !== 1'b0) begin errors++; $display("FAIL b2b_ready got=%b%b want=10", rd[7], rd[8]); end
    checks++;
    if (th1_pos !== 16'd2 || busy !== 1'b0) begin errors++; $display("FAIL b2b_pos got=%h busy=%b want=0002 busy=0", th1_pos, busy); end
  endtask

  initial begin
    fork
      begin
        #2_000_000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "timeout");
      end
    join_none
    test_reset();
    test_single();
    test_dual();
    test_zero();
    test_full_neg();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dual_stepper_driver.md
DUAL_STEPPER_DRIVER -- requirements
Module: dual_stepper_driver

Interface
REQ-001 SHALL have parameter STEP_HIGH_CYCLES, default 50, step pulse high time in clk cycles (>=1).
REQ-002 SHALL have parameter STEP_LOW_CYCLES, default 50, step pulse low time in clk cycles (>=1).
REQ-003 SHALL have parameter DIR_SETUP_CYCLES, default 10, dir-to-first-step setup time in clk cycles (>=1).
REQ-004 SHALL have one clock and a synchronous, active-low reset.
REQ-005 clk  input  1  sole clock; all logic on rising edge.
REQ-006 reset  input  1  synchronous, active-low reset.
REQ-007 th1_steps  input  9  joint-1 relative step command, two's complement.
REQ-008 th2_steps  input  9  joint-2 relative step command, two's complement.
REQ-009 cmd_valid  input  1  command present on th1_steps/th2_steps.
REQ-010 cmd_ready  output  1  block can accept a command.
REQ-011 abort  input  1  terminate the current move.
REQ-012 step1, step2  output  1 each  step pulse per joint.
REQ-013 dir1, dir2  output  1 each  direction per joint: 1 = positive, 0 = negative.
REQ-014 busy  output  1  move in progress.
REQ-015 done  output  1  one-cycle pulse at move end.
REQ-016 aborted  output  1  valid with done; 1 = the move ended by abort.
REQ-017 th1_pos, th2_pos  output  16 each  signed accumulated joint position in steps.

Function
REQ-018 The FSM SHALL have states IDLE, SETUP, PULSE_HI, PULSE_LO and DONE.
REQ-019 cmd_ready SHALL equal 1 only in IDLE; a command SHALL be accepted on a cycle with cmd_valid=1 and cmd_ready=1.
REQ-020 On acceptance, the block SHALL latch per axis: remaining = |cmd| as 9-bit unsigned (-256 -> 256), and dir = (cmd >= 0).
REQ-021 On acceptance with both commands zero, the FSM SHALL go to DONE next cycle with no step pulses and no dir change.
REQ-022 Otherwise the FSM SHALL go to SETUP; dir1/dir2 SHALL update on the first SETUP cycle and hold until the next accepted move.
REQ-023 SETUP SHALL last DIR_SETUP_CYCLES cycles, then go to PULSE_HI.
REQ-024 On PULSE_HI entry, for each axis with remaining > 0: step SHALL go high, remaining SHALL decrement by 1, and pos SHALL change by +1 (dir=1) or -1 (dir=0), modulo 2^16 with wrap-around.
REQ-025 An axis with remaining = 0 SHALL keep its step output low.
REQ-026 PULSE_HI SHALL last STEP_HIGH_CYCLES cycles; PULSE_LO SHALL last STEP_LOW_CYCLES cycles with both step outputs low.
REQ-027 At the end of PULSE_LO, the FSM SHALL go to PULSE_HI if either remaining > 0, else to DONE.
REQ-028 Both axes SHALL step concurrently; move length SHALL be max(|th1|, |th2|) pulse periods.
REQ-029 DONE SHALL last one cycle with done=1, then go to IDLE.
REQ-030 busy SHALL be 1 in SETUP, PULSE_HI, PULSE_LO and DONE.
REQ-031 abort=1 in SETUP, PULSE_HI or PULSE_LO SHALL, on the next cycle: force both step outputs low, clear remaining, and enter DONE with aborted=1.
REQ-032 A pulse truncated by abort SHALL still count in pos.
REQ-033 abort SHALL be ignored in IDLE and DONE.
REQ-034 With cmd_valid held high, the next command SHALL be accepted on the first IDLE cycle after DONE.
REQ-035 Command inputs SHALL be ignored except on the acceptance cycle.
REQ-036 Worst-case total move time SHALL be DIR_SETUP_CYCLES + 256*(STEP_HIGH_CYCLES + STEP_LOW_CYCLES) + 1 cycles; counters SHALL be sized for this.

Reset
REQ-037 On a clk edge with reset=0 the block SHALL enter IDLE and set: step1=step2=0, dir1=dir2=1, th1_pos=th2_pos=0, remaining=0, done=0, aborted=0, busy=0, cmd_ready=0.
REQ-038 cmd_ready SHALL be 1 from the first cycle after reset=1.
REQ-039 Reset mid-move SHALL take effect on the next edge, cut any pulse in progress, and not change pos further.

Verification (bench parameters: STEP_HIGH_CYCLES=2, STEP_LOW_CYCLES=2, DIR_SETUP_CYCLES=1; accept cycle = 0)
REQ-040 th1=+3, th2=0 -> dir1=1 from cycle 1; step1 high cycles 2-3, 6-7, 10-11; step2 never high; done at cycle 14; th1_pos=3.
REQ-041 th1=-2, th2=+5 -> dir1=0, dir2=1; step1 high cycles 2-3 and 6-7 only; step2 pulses 5 times; done at cycle 22; th1_pos=-2, th2_pos=5.
REQ-042 th1=0, th2=0 -> done at cycle 1; no step pulses; positions unchanged; cmd_ready=1 at cycle 2.
REQ-043 th1=-256 from th1_pos=0 -> 256 pulses; th1_pos=-256 (16'hFF00).
REQ-044 th1=+4 with abort at cycle 7 -> step1 low from cycle 8; done=1 and aborted=1 at cycle 8; th1_pos=2.
REQ-045 reset=0 at cycle 5 of a +3 move -> all outputs at REQ-037 values at cycle 6; cmd_ready=1 one cycle after reset is released.
